// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared channel encodings, MCU block count and scheduler state type
package jpeg_pkg;
  localparam logic [1:0] CH_Y = 2'd0, CH_CB = 2'd1, CH_CR = 2'd2;
  localparam int BLOCKS_PER_MCU = 6;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_e;
  function automatic logic [1:0] ch_of(input logic [2:0] idx);
    return idx < 3'd4 ? CH_Y : idx == 3'd4 ? CH_CB : CH_CR;
  endfunction
endpackage

// File: rtl/mcu_pos_counter.sv
// mcu_pos_counter: MCU raster position (x, y) within a width x height frame
module mcu_pos_counter #(
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] x,
  output logic [DIM_W-1:0] y,
  output logic             last
);
  logic x_end;
  assign x_end = x == width - 1'b1;
  assign last = x_end && y == height - 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      x <= x_end ? '0 : x + 1'b1;
      y <= last ? '0 : x_end ? y + 1'b1 : y;
    end
endmodule

// File: rtl/jpeg_mcu_scheduler.sv
// jpeg_mcu_scheduler: walks a 4:2:0 frame in MCU order, issues block channels,
// bounds MCUs in flight with credits and tags retired RGB blocks with coordinates
module jpeg_mcu_scheduler
  import jpeg_pkg::*;
#(
  parameter int DIM_W    = 12,
  parameter int CREDITS  = 2,
  parameter int Y_BLOCKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] width_mcus,
  input  logic [DIM_W-1:0] height_mcus,
  input  logic             blk_done,
  input  logic             rgb_valid,
  output logic             dec_en,
  output logic [1:0]       ch_sel,
  output logic [DIM_W-1:0] out_mcu_x,
  output logic [DIM_W-1:0] out_mcu_y,
  output logic [1:0]       out_sub,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);
  localparam int OW = $clog2(CREDITS + 1);
  localparam logic [OW-1:0] CRED = OW'(CREDITS);
  localparam logic [2:0] LAST_BLK = 3'(BLOCKS_PER_MCU - 1);
  localparam logic [1:0] LAST_SUB = 2'(Y_BLOCKS - 1);

  sched_state_e     state;
  logic [2:0]       blk_idx;
  logic [OW-1:0]    outstanding;
  logic [DIM_W-1:0] width, height, in_x, in_y;
  logic             in_last, out_last;
  logic             dims_ok, clear, blk_ok, issue, final_blk, rgb_ok, retire;

  assign dims_ok = |width_mcus && |height_mcus;
  assign clear = abort || (state == IDLE && start && dims_ok);
  // The credit guard also covers the cycle where registered dec_en still lags a full count
  assign blk_ok = blk_done && dec_en && state == RUN && outstanding < CRED;
  assign issue = blk_ok && blk_idx == LAST_BLK;
  assign final_blk = issue && in_last;
  assign rgb_ok = rgb_valid && outstanding != '0;
  assign retire = rgb_ok && out_sub == LAST_SUB;

  mcu_pos_counter #(.DIM_W(DIM_W)) u_in_pos (
    .clk(clk), .rst(rst), .clear(clear), .step(issue), .width(width), .height(height),
    .x(in_x), .y(in_y), .last(in_last)
  );

  mcu_pos_counter #(.DIM_W(DIM_W)) u_out_pos (
    .clk(clk), .rst(rst), .clear(clear), .step(retire), .width(width), .height(height),
    .x(out_mcu_x), .y(out_mcu_y), .last(out_last)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      blk_idx     <= '0;
      outstanding <= '0;
      width       <= '0;
      height      <= '0;
      dec_en      <= 1'b0;
      ch_sel      <= CH_Y;
      out_sub     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      blk_idx     <= '0;
      outstanding <= '0;
      dec_en      <= 1'b0;
      ch_sel      <= CH_Y;
      out_sub     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (state == IDLE && start) err <= !dims_ok;
      else if ((blk_done && !blk_ok) || (rgb_valid && !rgb_ok)) err <= 1'b1;
      outstanding <= outstanding + OW'(issue) - OW'(retire);
      if (blk_ok) begin
        blk_idx <= issue ? '0 : blk_idx + 1'b1;
        ch_sel  <= ch_of(issue ? 3'd0 : blk_idx + 1'b1);
      end
      if (rgb_ok) out_sub <= retire ? '0 : out_sub + 1'b1;
      dec_en     <= state == RUN && !final_blk && outstanding < CRED;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start && dims_ok) begin
          state  <= RUN;
          busy   <= 1'b1;
          width  <= width_mcus;
          height <= height_mcus;
        end
        RUN:  if (final_blk) state <= DRAIN;
        DRAIN: if (outstanding == '0) begin
          state      <= DONE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/jpeg_mcu_scheduler.md
Name: jpeg_mcu_scheduler

Overview:
Frame-level sequencer for the 4:2:0 JPEG decode pipeline (entropy decode -> dequant -> IDCT -> supersample -> channel buffer -> colour convert). It walks the frame in MCU raster order and issues the per-block channel select (Y0..Y3, Cb, Cr) to the entropy/dequant stages. It limits in-flight MCUs with a credit count, tags each RGB output block with its MCU coordinates, and signals frame completion.

Parameters:
DIM_W, 12, bit width of the MCU-count dimensions and coordinates.
CREDITS, 2, maximum number of MCUs in flight between block issue and RGB retirement (1..7).
Y_BLOCKS, 4, number of luma blocks per MCU; also the number of RGB blocks retired per MCU.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = reset).
start  in  1  one-cycle pulse; begins a frame. Honoured only in IDLE.
abort  in  1  synchronous clear to IDLE. Has priority over all other inputs.
width_mcus  in  DIM_W  frame width in MCUs. Sampled when start is accepted.
height_mcus  in  DIM_W  frame height in MCUs. Sampled when start is accepted.
blk_done  in  1  entropy decoder has completed one 8x8 block.
rgb_valid  in  1  colour converter emitted one RGB 8x8 block (valid_out_Color).
dec_en  out  1  entropy decoder permitted to fetch and decode.
ch_sel  out  2  channel of the block being decoded: 0 = Y, 1 = Cb, 2 = Cr.
out_mcu_x  out  DIM_W  MCU column of the current RGB output block.
out_mcu_y  out  DIM_W  MCU row of the current RGB output block.
out_sub  out  2  luma quadrant index (0..3) of the current RGB output block.
busy  out  1  high in RUN and DRAIN.
frame_done  out  1  one-cycle pulse at the end of a frame.
err  out  1  sticky protocol error flag. Cleared by start or abort.

Behaviour:
- Reset values: every output is 0; state = IDLE; all counters = 0.
- States:
  - IDLE: on start with both dimensions non-zero -> RUN. On start with either dimension zero, set err and stay in IDLE.
  - RUN: issue blocks. Leave for DRAIN on the issue of the final block of the last MCU.
  - DRAIN: dec_en = 0. Go to DONE when outstanding == 0.
  - DONE: frame_done = 1 for exactly one cycle, then IDLE.
- dec_en = (state == RUN) && (outstanding < CREDITS). It is registered and updates the cycle after outstanding changes.
- Block index blk_idx runs 0..5. ch_sel = 0 for indices 0-3, 1 for index 4, 2 for index 5. ch_sel is registered and valid while dec_en is high.
- blk_done while dec_en == 1: blk_idx increments. At index 5 it wraps to 0, outstanding increments, and the input MCU position advances.
- Input MCU position advance: x increments; when x == width-1, x returns to 0 and y increments.
- The final block is index 5 with x == width-1 and y == height-1.
- blk_done while dec_en == 0, or outside RUN: ignored and err set.
- rgb_valid while outstanding > 0: out_sub increments. At Y_BLOCKS-1 it wraps to 0, outstanding decrements, and the output position advances in the same raster order.
- rgb_valid while outstanding == 0: ignored and err set.
- out_mcu_x, out_mcu_y and out_sub describe the block currently presented by rgb_valid. They advance on the cycle after it.
- Same-cycle MCU issue and MCU retire: outstanding is unchanged.
- Latency: start -> dec_en = 1 is 2 cycles (state register, then dec_en register).
- Last rgb_valid of the frame -> frame_done pulse is 2 cycles later.
- A start arriving in RUN, DRAIN or DONE is ignored; no error is raised.
- abort or rst mid-frame: all counters clear, no frame_done is issued, and err is cleared.
- Arithmetic: position counters are DIM_W wide and compare against width-1 and height-1. outstanding is clog2(CREDITS+1) bits wide and never over- or underflows.

Decomposition:
- Shared package jpeg_pkg holds:
  - the CH_Y / CH_CB / CH_CR encodings;
  - the BLOCKS_PER_MCU = 6 constant;
  - the sched_state_e enum (IDLE, RUN, DRAIN, DONE).
- One sub-module, mcu_pos_counter, is instantiated twice: once for input position, once for output position.
  - Inputs: step, width, height, clear.
  - Outputs: x, y, last.

Test Plan:
- 1x1 frame, CREDITS = 2, six blk_done then four rgb_valid:
  - ch_sel sequence 0,0,0,0,1,2;
  - out positions (0,0) with sub 0..3;
  - frame_done 2 cycles after the 4th rgb_valid; err = 0.
- 3x2 frame, rgb_valid held off:
  - dec_en drops after 12 blk_done (2 MCUs);
  - one MCU retire (4 rgb_valid) re-raises dec_en;
  - the full frame ends with 36 blk_done, 24 rgb_valid and one frame_done.
- Retire and issue in the same cycle (6th blk_done coincides with 4th rgb_valid) -> outstanding unchanged; dec_en stays 1.
- Row wrap with width_mcus = 2: output coordinates read (0,0), (1,0), (0,1), (1,1).
- Error cases:
  - start with height_mcus = 0 -> err = 1, state stays IDLE;
  - rgb_valid in IDLE -> err = 1;
  - a following good start clears err.
- abort, and separately rst low, asserted mid-RUN with outstanding = 1:
  - all outputs return to 0 the next cycle (immediately for rst);
  - no frame_done is issued;
  - a new start then decodes a clean frame.
